// File: rtl/exp_ctrl_if.sv
// MM-commit to exception-controller bundle: committing-instruction state in,
// CP0 exception update strobes, flush and PC redirect out.
interface exp_ctrl_if;
    logic        mm_valid;
    logic [31:0] mm_pc;
    logic        mm_bd;
    logic [11:0] mm_exc;
    logic        mm_refill;
    logic        mm_eret;
    logic [31:0] mm_vaddr;
    logic [7:0]  mm_asid;

    logic        en_exp_o;
    logic [31:0] exp_epc;
    logic        exp_bd;
    logic [4:0]  exp_code;
    logic [31:0] exp_bad_vaddr;
    logic        exp_badv_we;
    logic [7:0]  exp_asid;
    logic        exp_asid_we;
    logic        clean_exl;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output mm_valid, mm_pc, mm_bd, mm_exc, mm_refill, mm_eret, mm_vaddr, mm_asid,
        input  en_exp_o, exp_epc, exp_bd, exp_code, exp_bad_vaddr, exp_badv_we,
               exp_asid, exp_asid_we, clean_exl, flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  mm_valid, mm_pc, mm_bd, mm_exc, mm_refill, mm_eret, mm_vaddr, mm_asid,
        output en_exp_o, exp_epc, exp_bd, exp_code, exp_bad_vaddr, exp_badv_we,
               exp_asid, exp_asid_we, clean_exl, flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exp_ctrl.sv
// Exception/interrupt controller: prioritises MM-stage exceptions and interrupts,
// drives CP0 update strobes, flush and PC redirect. EXP_INT_SYNC_EN selects a 2-flop hw_int_in synchronizer.
module exp_ctrl #(
    parameter int unsigned FLUSH_CYCLES   = 2,
    parameter logic [31:0] RESET_VEC_BASE = 32'hBFC00200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  hw_int_in,
    input  logic        timer_int,
    output logic [5:0]  hardware_int,
    input  logic        allow_int,
    input  logic [7:0]  interrupt_mask,
    input  logic [1:0]  software_int_i,
    input  logic        special_int_vec,
    input  logic        boot_exp_vec,
    input  logic [19:0] ebase,
    input  logic [31:0] epc,
    input  logic        in_exl,
    exp_ctrl_if.slave   bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [3:0] FLUSH_CNT = 4'(FLUSH_CYCLES);

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_MOD  = 5'd1;
    localparam logic [4:0] CODE_TLBL = 5'd2;
    localparam logic [4:0] CODE_TLBS = 5'd3;
    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_BP   = 5'd9;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_OV   = 5'd12;

    // Index of the lowest set flag; lower index means higher priority.
    function automatic logic [3:0] first_set(input logic [11:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    logic [4:0] hw_sync_q;

`ifdef EXP_INT_SYNC_EN
    logic [4:0] hw_meta_q;

    // Two-flop synchronizer for the asynchronous interrupt lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw_meta_q <= 5'd0;
            hw_sync_q <= 5'd0;
        end else begin
            hw_meta_q <= hw_int_in;
            hw_sync_q <= hw_meta_q;
        end
    end
`else
    // Single register stage on the interrupt lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw_sync_q <= 5'd0;
        end else begin
            hw_sync_q <= hw_int_in;
        end
    end
`endif

    // timer_int comes from cp0 on this clock, so it bypasses the synchronizer.
    assign hardware_int = {timer_int, hw_sync_q};

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;

    logic        int_pend_s;
    logic        exc_any_s;
    logic        take_s;
    logic [3:0]  exc_idx_s;
    logic        is_int_s;
    logic        is_eret_s;
    logic [4:0]  code_s;
    logic [31:0] badv_s;
    logic        badv_we_s;
    logic        asid_we_s;
    logic        refill_s;
    logic [31:0] base_s;
    logic [31:0] offset_s;
    logic [31:0] target_s;
    logic [31:0] epc_s;

    assign int_pend_s = allow_int & (|({hardware_int, software_int_i} & interrupt_mask));
    assign exc_any_s  = |bus.mm_exc;
    assign take_s     = (state_q == ST_IDLE) & bus.mm_valid & (int_pend_s | exc_any_s | bus.mm_eret);
    assign exc_idx_s  = first_set(bus.mm_exc);
    assign epc_s      = bus.mm_bd ? (bus.mm_pc - 32'd4) : bus.mm_pc;

    // Classify the winning cause: interrupt, then flags by index, then ERET.
    always_comb begin
        is_int_s  = 1'b0;
        is_eret_s = 1'b0;
        code_s    = CODE_INT;
        badv_s    = 32'd0;
        badv_we_s = 1'b0;
        asid_we_s = 1'b0;
        refill_s  = 1'b0;
        if (int_pend_s) begin
            is_int_s = 1'b1;
        end else if (exc_any_s) begin
            case (exc_idx_s)
                4'd0:  begin code_s = CODE_ADEL; badv_s = bus.mm_pc; badv_we_s = 1'b1; end
                4'd1:  begin code_s = CODE_TLBL; badv_s = bus.mm_pc; badv_we_s = 1'b1;
                             asid_we_s = 1'b1; refill_s = 1'b1; end
                4'd2:  begin code_s = CODE_TLBL; badv_s = bus.mm_pc; badv_we_s = 1'b1;
                             asid_we_s = 1'b1; end
                4'd3:  code_s = CODE_RI;
                4'd4:  code_s = CODE_SYS;
                4'd5:  code_s = CODE_BP;
                4'd6:  code_s = CODE_OV;
                4'd7:  begin code_s = CODE_ADEL; badv_s = bus.mm_vaddr; badv_we_s = 1'b1; end
                4'd8:  begin code_s = CODE_ADES; badv_s = bus.mm_vaddr; badv_we_s = 1'b1; end
                4'd9:  begin code_s = CODE_TLBL; badv_s = bus.mm_vaddr; badv_we_s = 1'b1;
                             asid_we_s = 1'b1; refill_s = bus.mm_refill; end
                4'd10: begin code_s = CODE_TLBS; badv_s = bus.mm_vaddr; badv_we_s = 1'b1;
                             asid_we_s = 1'b1; refill_s = bus.mm_refill; end
                4'd11: begin code_s = CODE_MOD; badv_s = bus.mm_vaddr; badv_we_s = 1'b1;
                             asid_we_s = 1'b1; end
                default: code_s = CODE_INT;
            endcase
        end else begin
            is_eret_s = bus.mm_eret;
        end
    end

    // Vector selection; a refill taken while already in EXL uses the general vector.
    always_comb begin
        base_s = boot_exp_vec ? (RESET_VEC_BASE - 32'h0000_0200) : {ebase, 12'h000};
        if (refill_s && !in_exl) begin
            offset_s = 32'h0000_0000;
        end else if (is_int_s && special_int_vec) begin
            offset_s = 32'h0000_0200;
        end else begin
            offset_s = 32'h0000_0180;
        end
        if (is_eret_s) begin
            target_s = epc;
        end else begin
            target_s = base_s + offset_s;
        end
    end

    // Flush sequencer next state: load on take, count down, release at 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;
        case (state_q)
            ST_IDLE: begin
                if (take_s) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_CNT;
                    flush_d = 1'b1;
                end else begin
                    cnt_d   = 4'd0;
                    flush_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    flush_d = 1'b0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                flush_d = 1'b0;
            end
        endcase
    end

    // Flush sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
        end
    end

    logic        en_exp_q;
    logic [31:0] exp_epc_q;
    logic        exp_bd_q;
    logic [4:0]  exp_code_q;
    logic [31:0] exp_bad_vaddr_q;
    logic        exp_badv_we_q;
    logic [7:0]  exp_asid_q;
    logic        exp_asid_we_q;
    logic        clean_exl_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;

    // One-cycle CP0 update and redirect; fields read as zero outside that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_exp_q         <= 1'b0;
            exp_epc_q        <= 32'd0;
            exp_bd_q         <= 1'b0;
            exp_code_q       <= 5'd0;
            exp_bad_vaddr_q  <= 32'd0;
            exp_badv_we_q    <= 1'b0;
            exp_asid_q       <= 8'd0;
            exp_asid_we_q    <= 1'b0;
            clean_exl_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else if (take_s) begin
            en_exp_q         <= ~is_eret_s;
            exp_epc_q        <= epc_s;
            exp_bd_q         <= bus.mm_bd;
            exp_code_q       <= code_s;
            exp_bad_vaddr_q  <= badv_s;
            exp_badv_we_q    <= badv_we_s;
            exp_asid_q       <= bus.mm_asid;
            exp_asid_we_q    <= asid_we_s;
            clean_exl_q      <= is_eret_s;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= target_s;
        end else begin
            en_exp_q         <= 1'b0;
            exp_epc_q        <= 32'd0;
            exp_bd_q         <= 1'b0;
            exp_code_q       <= 5'd0;
            exp_bad_vaddr_q  <= 32'd0;
            exp_badv_we_q    <= 1'b0;
            exp_asid_q       <= 8'd0;
            exp_asid_we_q    <= 1'b0;
            clean_exl_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end
    end

    assign bus.en_exp_o       = en_exp_q;
    assign bus.exp_epc        = exp_epc_q;
    assign bus.exp_bd         = exp_bd_q;
    assign bus.exp_code       = exp_code_q;
    assign bus.exp_bad_vaddr  = exp_bad_vaddr_q;
    assign bus.exp_badv_we    = exp_badv_we_q;
    assign bus.exp_asid       = exp_asid_q;
    assign bus.exp_asid_we    = exp_asid_we_q;
    assign bus.clean_exl      = clean_exl_q;
    assign bus.flush          = flush_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exp_ctrl.sv
// Randomized + directed bench for exp_ctrl against a cause-table reference model.
module tb_exp_ctrl;

    localparam int FC = 2;
`ifdef EXP_INT_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  hw_int_in = 5'd0;
    logic        timer_int = 1'b0;
    logic [5:0]  hardware_int;
    logic        allow_int = 1'b0;
    logic [7:0]  interrupt_mask = 8'd0;
    logic [1:0]  software_int_i = 2'd0;
    logic        special_int_vec = 1'b0;
    logic        boot_exp_vec = 1'b0;
    logic [19:0] ebase = 20'h80000;
    logic [31:0] epc = 32'd0;
    logic        in_exl = 1'b0;

    exp_ctrl_if bus();

    exp_ctrl dut (
        .clk(clk), .rst_n(rst_n), .hw_int_in(hw_int_in), .timer_int(timer_int),
        .hardware_int(hardware_int), .allow_int(allow_int), .interrupt_mask(interrupt_mask),
        .software_int_i(software_int_i), .special_int_vec(special_int_vec),
        .boot_exp_vec(boot_exp_vec), .ebase(ebase), .epc(epc), .in_exl(in_exl), .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int code_tab[12] = '{4, 2, 2, 10, 8, 9, 12, 4, 5, 2, 3, 1};
    int          m_flush_left = 0;
    logic [4:0]  hq[$];
    logic        e_en = 1'b0, e_cl = 1'b0, e_rv = 1'b0, e_bw = 1'b0, e_aw = 1'b0;
    logic        e_bd = 1'b0;
    logic [4:0]  e_code = 5'd0;
    logic [31:0] e_epc = 32'd0, e_badv = 32'd0, e_rpc = 32'd0;
    logic [7:0]  e_asid = 8'd0;

    function automatic logic [4:0] sync_now();
        if (hq.size() >= SYNC_LAT) return hq[SYNC_LAT-1];
        return 5'd0;
    endfunction

    task automatic model_step();
        logic [5:0]  hwint;
        logic        pend, isint, iseret, refill;
        int          idx;
        logic [31:0] base, off;
        hwint = {timer_int, sync_now()};
        pend  = allow_int && ((({hwint, software_int_i}) & interrupt_mask) != 8'd0);
        e_en = 1'b0; e_cl = 1'b0; e_rv = 1'b0; e_bw = 1'b0; e_aw = 1'b0;
        if (m_flush_left == 0) begin
            if (bus.mm_valid && (pend || (bus.mm_exc != 12'd0) || bus.mm_eret)) begin
                isint = pend; iseret = 1'b0; refill = 1'b0; idx = -1;
                e_code = 5'd0; e_badv = 32'd0;
                if (!pend) begin
                    for (int i = 0; i < 12; i++)
                        if (idx < 0 && bus.mm_exc[i]) idx = i;
                    if (idx < 0) iseret = 1'b1;
                end
                if (idx >= 0) begin
                    e_code = 5'(code_tab[idx]);
                    if (idx <= 2) begin e_bw = 1'b1; e_badv = bus.mm_pc; end
                    if (idx >= 7) begin e_bw = 1'b1; e_badv = bus.mm_vaddr; end
                    e_aw = (idx == 1 || idx == 2 || idx >= 9);
                    refill = (idx == 1) || ((idx == 9 || idx == 10) && bus.mm_refill);
                end
                base = boot_exp_vec ? 32'hBFC00000 : {ebase, 12'h000};
                if (refill && !in_exl) off = 32'h0;
                else if (isint && special_int_vec) off = 32'h200;
                else off = 32'h180;
                e_en   = !iseret;
                e_cl   = iseret;
                e_rv   = 1'b1;
                e_rpc  = iseret ? epc : base + off;
                e_epc  = bus.mm_bd ? bus.mm_pc - 32'd4 : bus.mm_pc;
                e_bd   = bus.mm_bd;
                e_asid = bus.mm_asid;
                m_flush_left = FC;
            end
        end else begin
            m_flush_left--;
        end
        hq.push_front(hw_int_in);
        if (hq.size() > 4) void'(hq.pop_back());
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_flush_left = 0;
                hq.delete();
                e_en = 1'b0; e_cl = 1'b0; e_rv = 1'b0; e_bw = 1'b0; e_aw = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("hardware_int", 32'(hardware_int), 32'({timer_int, sync_now()}));
            chk("en_exp_o", 32'(bus.en_exp_o), 32'(e_en));
            chk("clean_exl", 32'(bus.clean_exl), 32'(e_cl));
            chk("redirect_valid", 32'(bus.redirect_valid), 32'(e_rv));
            chk("flush", 32'(bus.flush), 32'(m_flush_left > 0));
            chk("badv_we", 32'(bus.exp_badv_we), 32'(e_bw));
            chk("asid_we", 32'(bus.exp_asid_we), 32'(e_aw));
            if (e_en) begin
                chk("exp_code", 32'(bus.exp_code), 32'(e_code));
                chk("exp_epc", bus.exp_epc, e_epc);
                chk("exp_bd", 32'(bus.exp_bd), 32'(e_bd));
                chk("bad_vaddr", bus.exp_bad_vaddr, e_badv);
            end
            if (e_aw) chk("exp_asid", 32'(bus.exp_asid), 32'(e_asid));
            if (e_rv) chk("redirect_pc", bus.redirect_pc, e_rpc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic mm_clear();
        bus.mm_valid = 1'b0; bus.mm_exc = 12'd0; bus.mm_eret = 1'b0;
        bus.mm_bd = 1'b0; bus.mm_refill = 1'b0;
    endtask

    task automatic wait_flush();
        mm_clear();
        repeat (FC) tick();
    endtask

    initial begin
        int lat;
        mm_clear();
        bus.mm_pc = 32'd0; bus.mm_vaddr = 32'd0; bus.mm_asid = 8'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_en", 32'(bus.en_exp_o), 32'd0);
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_rv", 32'(bus.redirect_valid), 32'd0);
        chk("rst_hwint", 32'(hardware_int), 32'd0);
        rst_n = 1'b1;
        tick();

        // Sys, no delay slot
        bus.mm_valid = 1'b1; bus.mm_pc = 32'h80001000; bus.mm_exc = 12'h010;
        tick();
        chk("sys_en", 32'(bus.en_exp_o), 32'd1);
        chk("sys_code", 32'(bus.exp_code), 32'd8);
        chk("sys_epc", bus.exp_epc, 32'h80001000);
        chk("sys_rpc", bus.redirect_pc, 32'h80000180);
        mm_clear();
        tick();
        chk("sys_flush2", 32'(bus.flush), 32'd1);
        tick();
        chk("sys_flush3", 32'(bus.flush), 32'd0);

        // Ov in delay slot
        bus.mm_valid = 1'b1; bus.mm_pc = 32'h80000104; bus.mm_bd = 1'b1; bus.mm_exc = 12'h040;
        tick();
        chk("ov_bd", 32'(bus.exp_bd), 32'd1);
        chk("ov_epc", bus.exp_epc, 32'h80000100);
        chk("ov_code", 32'(bus.exp_code), 32'd12);
        chk("ov_bw", 32'(bus.exp_badv_we), 32'd0);
        wait_flush();

        // data TLBL refill, then same with EXL set
        for (int k = 0; k < 2; k++) begin
            in_exl = k[0];
            bus.mm_valid = 1'b1; bus.mm_pc = 32'h80003000; bus.mm_exc = 12'h200;
            bus.mm_refill = 1'b1; bus.mm_vaddr = 32'h00400010; bus.mm_asid = 8'h03;
            tick();
            chk("tlb_code", 32'(bus.exp_code), 32'd2);
            chk("tlb_badv", bus.exp_bad_vaddr, 32'h00400010);
            chk("tlb_aw", 32'(bus.exp_asid_we), 32'd1);
            chk("tlb_rpc", bus.redirect_pc, (k == 0) ? 32'h80000000 : 32'h80000180);
            wait_flush();
        end
        in_exl = 1'b0;

        // interrupt latency and vectored offset
        allow_int = 1'b1; interrupt_mask = 8'h10; special_int_vec = 1'b1;
        bus.mm_valid = 1'b1; bus.mm_pc = 32'h80004000; hw_int_in = 5'b00100;
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            lat++;
            if (bus.en_exp_o) break;
        end
        chk("int_latency", 32'(lat), 32'(SYNC_LAT + 1));
        chk("int_code", 32'(bus.exp_code), 32'd0);
        chk("int_rpc", bus.redirect_pc, 32'h80000200);
        wait_flush();
        repeat (5) begin
            tick();
            chk("int_blocked", 32'(bus.en_exp_o), 32'd0);
        end
        bus.mm_valid = 1'b1;
        tick();
        chk("int_late_take", 32'(bus.en_exp_o), 32'd1);
        hw_int_in = 5'd0; allow_int = 1'b0; special_int_vec = 1'b0; interrupt_mask = 8'd0;
        wait_flush();
        repeat (SYNC_LAT) tick();

        // ERET, then a Sys offered during flush is dropped
        epc = 32'h80002000;
        bus.mm_valid = 1'b1; bus.mm_eret = 1'b1;
        tick();
        chk("eret_cl", 32'(bus.clean_exl), 32'd1);
        chk("eret_en", 32'(bus.en_exp_o), 32'd0);
        chk("eret_rpc", bus.redirect_pc, 32'h80002000);
        bus.mm_eret = 1'b0; bus.mm_exc = 12'h010;
        tick();
        mm_clear();
        tick();
        chk("eret_drop", 32'(bus.en_exp_o), 32'd0);

        // reset in the middle of a flush
        bus.mm_valid = 1'b1; bus.mm_exc = 12'h010;
        tick();
        mm_clear();
        chk("mid_flush_pre", 32'(bus.flush), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("mid_flush_rst", 32'(bus.flush), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int sel;
            bus.mm_valid  = ($urandom_range(0, 1) == 1);
            bus.mm_pc     = {$urandom_range(0, 65535), 14'd0, 2'd0};
            bus.mm_bd     = ($urandom_range(0, 3) == 0);
            bus.mm_refill = ($urandom_range(0, 1) == 1);
            bus.mm_eret   = ($urandom_range(0, 7) == 0);
            bus.mm_vaddr  = $urandom;
            bus.mm_asid   = 8'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 5) bus.mm_exc = 12'd0;
            else if (sel < 8) bus.mm_exc = 12'd1 << $urandom_range(0, 11);
            else bus.mm_exc = 12'($urandom);
            if ($urandom_range(0, 15) == 0) hw_int_in = 5'($urandom);
            timer_int       = ($urandom_range(0, 15) == 0);
            allow_int       = ($urandom_range(0, 3) != 0);
            interrupt_mask  = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'd0;
            software_int_i  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'd0;
            special_int_vec = ($urandom_range(0, 1) == 1);
            boot_exp_vec    = ($urandom_range(0, 3) == 0);
            in_exl          = ($urandom_range(0, 2) == 0);
            ebase           = {2'b10, 18'($urandom)};
            epc             = $urandom;
            tick();
        end

        mm_clear();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
